// File: rtl/socket_mem_sched.sv
// Fixed-priority scheduler with starvation override from per-socket requesters onto one memory port.
// One-cycle request latency through a single output register; responses routed by tag with zero latency.
module socket_mem_sched #(
  parameter int NUM_INPUTS  = 2,
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_WIDTH  = 512,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_STARVE  = 15,
  parameter int MAX_PENDING = 16,
  localparam int LOG_N      = $clog2(NUM_INPUTS),
  localparam int BE_WIDTH   = DATA_WIDTH / 8,
  localparam int OTAG_WIDTH = TAG_WIDTH + LOG_N
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            in_req_valid,
  input  logic [NUM_INPUTS-1:0]            in_req_rw,
  input  logic [NUM_INPUTS*ADDR_WIDTH-1:0] in_req_addr,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_req_data,
  input  logic [NUM_INPUTS*BE_WIDTH-1:0]   in_req_byteen,
  input  logic [NUM_INPUTS*TAG_WIDTH-1:0]  in_req_tag,
  output logic [NUM_INPUTS-1:0]            in_req_ready,
  output logic [NUM_INPUTS-1:0]            in_rsp_valid,
  output logic [DATA_WIDTH-1:0]            in_rsp_data,
  output logic [TAG_WIDTH-1:0]             in_rsp_tag,
  input  logic [NUM_INPUTS-1:0]            in_rsp_ready,
  output logic                             mem_req_valid,
  output logic                             mem_req_rw,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_data,
  output logic [BE_WIDTH-1:0]              mem_req_byteen,
  output logic [OTAG_WIDTH-1:0]            mem_req_tag,
  input  logic                             mem_req_ready,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
  input  logic [OTAG_WIDTH-1:0]            mem_rsp_tag,
  output logic                             mem_rsp_ready,
  output logic                             busy,
  output logic                             err_bad_rsp
);

  logic [7:0]            starve [NUM_INPUTS];
  logic [7:0]            pend   [NUM_INPUTS];
  logic                  can_load;
  logic [NUM_INPUTS-1:0] elig;
  logic [NUM_INPUTS-1:0] grant;
  logic                  gnt_any;
  logic [LOG_N-1:0]      gnt_idx;
  logic [LOG_N-1:0]      rsp_idx;
  logic                  route_ok;
  logic                  pend_nz;

  assign can_load = !mem_req_valid | mem_req_ready;

  // Descending scans leave the lowest index; the forced scan runs last so it overrides.
  always_comb begin
    elig    = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++)
      elig[i] = in_req_valid[i] & (in_req_rw[i] | (pend[i] < 8'(MAX_PENDING)));
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        gnt_idx = LOG_N'(i);
        gnt_any = 1'b1;
      end
    end
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (elig[i] && starve[i] == 8'(MAX_STARVE))
        gnt_idx = LOG_N'(i);
    end
    gnt_any = gnt_any & can_load & reset;
    grant   = gnt_any ? (NUM_INPUTS'(1) << gnt_idx) : '0;
  end

  assign in_req_ready = grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_valid  <= 1'b0;
      mem_req_rw     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_data   <= '0;
      mem_req_byteen <= '0;
      mem_req_tag    <= '0;
    end else if (can_load) begin
      mem_req_valid <= gnt_any;
      if (gnt_any) begin
        mem_req_rw     <= in_req_rw[gnt_idx];
        mem_req_addr   <= in_req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        mem_req_data   <= in_req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        mem_req_byteen <= in_req_byteen[gnt_idx*BE_WIDTH +: BE_WIDTH];
        mem_req_tag    <= {in_req_tag[gnt_idx*TAG_WIDTH +: TAG_WIDTH], gnt_idx};
      end
    end
  end

  // A response is only routable to an input that still has a read outstanding.
  always_comb begin
    rsp_idx       = mem_rsp_tag[LOG_N-1:0];
    route_ok      = 1'b0;
    in_rsp_valid  = '0;
    mem_rsp_ready = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (rsp_idx == LOG_N'(i) && pend[i] != 8'd0) begin
        route_ok        = 1'b1;
        in_rsp_valid[i] = mem_rsp_valid;
        mem_rsp_ready   = in_rsp_ready[i];
      end
    end
    mem_rsp_ready = mem_rsp_ready & reset;
    in_rsp_tag    = reset ? mem_rsp_tag[OTAG_WIDTH-1:LOG_N] : '0;
    in_rsp_data   = reset ? mem_rsp_data : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        starve[i] <= 8'd0;
        pend[i]   <= 8'd0;
      end
      err_bad_rsp <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (grant[i])
          starve[i] <= 8'd0;
        else if (can_load && elig[i] && starve[i] != 8'(MAX_STARVE))
          starve[i] <= starve[i] + 8'd1;
        case ({grant[i] & ~in_req_rw[i], in_rsp_valid[i] & in_rsp_ready[i]})
          2'b10:   pend[i] <= pend[i] + 8'd1;
          2'b01:   pend[i] <= pend[i] - 8'd1;
          default: pend[i] <= pend[i];
        endcase
      end
      if (mem_rsp_valid && !route_ok)
        err_bad_rsp <= 1'b1;
    end
  end

  always_comb begin
    pend_nz = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++)
      pend_nz = pend_nz | (pend[i] != 8'd0);
  end

  assign busy = mem_req_valid | pend_nz;

endmodule

// File: tb/tb_socket_mem_sched.sv
// Randomized scoreboard bench for socket_mem_sched against a rule-level reference model.
module tb_socket_mem_sched;
  localparam int N   = 2;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TW  = 8;
  localparam int MS  = 3;
  localparam int MP  = 4;
  localparam int LN  = 1;
  localparam int BW  = DW / 8;
  localparam int OTW = TW + LN;

  logic            clk;
  logic            reset;
  logic [N-1:0]    in_req_valid, in_req_rw, in_req_ready, in_rsp_valid, in_rsp_ready;
  logic [N*AW-1:0] in_req_addr;
  logic [N*DW-1:0] in_req_data;
  logic [N*BW-1:0] in_req_byteen;
  logic [N*TW-1:0] in_req_tag;
  logic [DW-1:0]   in_rsp_data;
  logic [TW-1:0]   in_rsp_tag;
  logic            mem_req_valid, mem_req_rw, mem_req_ready;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [BW-1:0]   mem_req_byteen;
  logic [OTW-1:0]  mem_req_tag;
  logic            mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0]   mem_rsp_data;
  logic [OTW-1:0]  mem_rsp_tag;
  logic            busy, err_bad_rsp;

  socket_mem_sched #(.NUM_INPUTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
                     .MAX_STARVE(MS), .MAX_PENDING(MP)) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
    .in_req_data(in_req_data), .in_req_byteen(in_req_byteen), .in_req_tag(in_req_tag),
    .in_req_ready(in_req_ready), .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data),
    .in_rsp_tag(in_rsp_tag), .in_rsp_ready(in_rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_byteen(mem_req_byteen), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .busy(busy), .err_bad_rsp(err_bad_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Stimulus for the next cycle
  logic [N-1:0]  d_vld, d_rw, d_rsp_rdy;
  logic [AW-1:0] d_addr [N];
  logic [DW-1:0] d_data [N];
  logic [BW-1:0] d_be   [N];
  logic [TW-1:0] d_tag  [N];
  logic          d_mready, d_rsp_en;
  int            d_rsp_idx;
  logic [TW-1:0] d_rsp_tag;
  logic [DW-1:0] d_rsp_data;

  // Reference model state
  int   m_pend   [N];
  int   m_starve [N];
  logic m_out;
  logic m_err;

  logic [63:0] exp_req_q [$];
  logic [63:0] exp_rsp_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic model_busy();
    logic b = m_out;
    for (int i = 0; i < N; i++) if (m_pend[i] != 0) b = 1'b1;
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_starve[i] = 0;
    end
    m_out = 1'b0;
    m_err = 1'b0;
    exp_req_q.delete();
    exp_rsp_q.delete();
  endtask

  task automatic idle_stim();
    d_vld = '0; d_rw = '0; d_rsp_rdy = '0; d_mready = 1'b1; d_rsp_en = 1'b0;
    d_rsp_idx = 0; d_rsp_tag = '0; d_rsp_data = '0;
    for (int i = 0; i < N; i++) begin
      d_addr[i] = '0; d_data[i] = '0; d_be[i] = '0; d_tag[i] = '0;
    end
  endtask

  // One clock: apply stimulus, predict the DUT's reaction from the rules, advance the model.
  task automatic step();
    int            pick;
    logic          cl, good;
    logic [N-1:0]  el;
    int            ri;
    @(negedge clk);
    in_req_valid = d_vld;
    in_req_rw    = d_rw;
    for (int i = 0; i < N; i++) begin
      in_req_addr[i*AW +: AW]   = d_addr[i];
      in_req_data[i*DW +: DW]   = d_data[i];
      in_req_byteen[i*BW +: BW] = d_be[i];
      in_req_tag[i*TW +: TW]    = d_tag[i];
    end
    mem_req_ready = d_mready;
    in_rsp_ready  = d_rsp_rdy;
    mem_rsp_valid = d_rsp_en;
    mem_rsp_tag   = {d_rsp_tag, LN'(d_rsp_idx)};
    mem_rsp_data  = d_rsp_data;
    #1;
    cl = !m_out || d_mready;
    for (int i = 0; i < N; i++) el[i] = d_vld[i] && (d_rw[i] || m_pend[i] < MP);
    pick = -1;
    if (cl) begin
      for (int i = 0; i < N; i++) if (pick < 0 && el[i] && m_starve[i] == MS) pick = i;
      for (int i = 0; i < N; i++) if (pick < 0 && el[i]) pick = i;
    end
    chk("in_req_ready", 64'(in_req_ready), pick >= 0 ? (64'(1) << pick) : 64'(0));
    chk("mem_req_valid", 64'(mem_req_valid), 64'(m_out));
    chk("busy", 64'(busy), 64'(model_busy()));
    chk("err_bad_rsp", 64'(err_bad_rsp), 64'(m_err));
    ri   = d_rsp_idx;
    good = d_rsp_en && ri < N && m_pend[ri] > 0;
    if (d_rsp_en) chk("mem_rsp_ready", 64'(mem_rsp_ready), good ? 64'(d_rsp_rdy[ri]) : 64'(1));
    chk("in_rsp_valid", 64'(in_rsp_valid), good ? (64'(1) << ri) : 64'(0));
    if (good && d_rsp_rdy[ri]) begin
      exp_rsp_q.push_back(64'({1'(ri), d_rsp_tag, d_rsp_data}));
      m_pend[ri]--;
    end
    if (d_rsp_en && !good) m_err = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i == pick) m_starve[i] = 0;
      else if (cl && el[i] && m_starve[i] < MS) m_starve[i]++;
    end
    if (pick >= 0) begin
      exp_req_q.push_back(64'({d_rw[pick], d_addr[pick], d_data[pick], d_be[pick],
                               d_tag[pick], LN'(pick)}));
      if (!d_rw[pick]) m_pend[pick]++;
      m_out = 1'b1;
    end else if (d_mready) begin
      m_out = 1'b0;
    end
  endtask

  // Monitor: compare each accepted mem request and each delivered response in order.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset && mem_req_valid && mem_req_ready) begin
        if (exp_req_q.size() == 0) chk("mem_req_unexpected", 64'(1), 64'(0));
        else chk("mem_req", 64'({mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen,
                                 mem_req_tag}), exp_req_q.pop_front());
      end
      for (int i = 0; i < N; i++) begin
        if (in_rsp_valid[i] && in_rsp_ready[i]) begin
          if (exp_rsp_q.size() == 0) chk("in_rsp_unexpected", 64'(1), 64'(0));
          else chk("in_rsp", 64'({1'(i), in_rsp_tag, in_rsp_data}), exp_rsp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int k;
    reset = 1'b0;
    in_req_valid = 2'b11; in_req_rw = '0; in_req_addr = '0; in_req_data = '0;
    in_req_byteen = '0; in_req_tag = '0; in_rsp_ready = '1;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_tag = '0;
    model_clear();
    idle_stim();
    #3;
    chk("rst_in_req_ready", 64'(in_req_ready), 64'(0));
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err_bad_rsp), 64'(0));
    in_req_valid = '0;
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic with backpressure and in-range responses
    for (int c = 0; c < 800; c++) begin
      int ri;
      for (int i = 0; i < N; i++) begin
        d_vld[i]  = ($urandom_range(0, 3) != 0);
        d_rw[i]   = ($urandom_range(0, 2) == 0);
        d_addr[i] = AW'($urandom);
        d_data[i] = DW'($urandom);
        d_be[i]   = BW'($urandom);
        d_tag[i]  = TW'($urandom);
      end
      d_mready  = ($urandom_range(0, 3) != 0);
      d_rsp_rdy = N'($urandom);
      ri = int'($urandom_range(0, N - 1));
      d_rsp_en   = ($urandom_range(0, 2) == 0) && m_pend[ri] > 0;
      d_rsp_idx  = ri;
      d_rsp_tag  = TW'($urandom);
      d_rsp_data = DW'($urandom);
      step();
    end

    // Drain all outstanding reads
    idle_stim();
    k = 0;
    while (model_busy() && k < 300) begin
      idle_stim();
      d_rsp_rdy = '1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i] > 0) begin d_rsp_en = 1'b1; d_rsp_idx = i; end
      d_rsp_tag = TW'($urandom);
      d_rsp_data = DW'($urandom);
      step();
      k++;
    end
    if (model_busy()) chk("drain_timeout", 64'(k), 64'(0));
    idle_stim();
    step();

    // Read on input 1 with tag 0x2A, then its response
    idle_stim();
    d_vld = 2'b10; d_tag[1] = 8'h2A; d_addr[1] = 16'h1234; d_data[1] = 32'hCAFE_0001; d_be[1] = 4'hF;
    step();
    idle_stim();
    step();
    chk("tag_encode", 64'(mem_req_tag), 64'h055);
    chk("busy_read_outstanding", 64'(busy), 64'(1));
    idle_stim();
    d_rsp_en = 1'b1; d_rsp_idx = 1; d_rsp_tag = 8'h2A; d_rsp_data = 32'hBEEF_0055; d_rsp_rdy = 2'b10;
    step();
    chk("in_rsp_valid_route", 64'(in_rsp_valid), 64'(2'b10));
    chk("in_rsp_tag_route", 64'(in_rsp_tag), 64'h2A);
    idle_stim();
    step();
    chk("busy_after_rsp", 64'(busy), 64'(0));

    // Response with no outstanding read on the tagged input
    idle_stim();
    d_rsp_en = 1'b1; d_rsp_idx = 1; d_rsp_tag = 8'h2A; d_rsp_rdy = 2'b00;
    step();
    idle_stim();
    step();
    step();
    chk("err_sticky", 64'(err_bad_rsp), 64'(1));

    // Build three outstanding reads on input 0, then reset asynchronously
    idle_stim();
    for (int j = 0; j < 3; j++) begin
      d_vld = 2'b01; d_tag[0] = TW'(j + 1); d_addr[0] = AW'(j);
      step();
    end
    @(negedge clk);
    reset = 1'b0;
    in_req_valid = 2'b11;
    mem_rsp_valid = 1'b1;
    mem_rsp_tag = '0;
    #1;
    chk("arst_in_req_ready", 64'(in_req_ready), 64'(0));
    chk("arst_mem_req_valid", 64'(mem_req_valid), 64'(0));
    chk("arst_in_rsp_valid", 64'(in_rsp_valid), 64'(0));
    chk("arst_mem_rsp_ready", 64'(mem_rsp_ready), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_err", 64'(err_bad_rsp), 64'(0));
    model_clear();
    in_req_valid = '0;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle_stim();
    d_rsp_en = 1'b1; d_rsp_idx = 0; d_rsp_tag = 8'h03; d_rsp_rdy = 2'b01;
    step();
    idle_stim();
    step();
    chk("late_rsp_err", 64'(err_bad_rsp), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
